// File: rtl/router_dst_reader.sv
// router_dst_reader: destination-side reader for one router output channel.
// Drains the channel FIFO, parses {len,addr} header / payload / parity packets
// and streams payload bytes on a valid/ready interface with sop/eop markers.
// Optional build macro: ROUTER_RD_PARITY_CHK_EN builds the parity accumulator
// and drives pkt_err; without it pkt_err is tied low.
module router_dst_reader #(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic             router_clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_enb,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [5:0]       pkt_len,
  output logic [1:0]       pkt_addr,
  output logic             pkt_done,
  output logic             pkt_err
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int ENT_W = WIDTH + 2;

  typedef enum logic [1:0] {HDR, PAY, PAR} state_t;

  state_t           state, state_nxt;
  logic             clr;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0] buf_mem [BUF_DEPTH];
  logic [ENT_W-1:0] head;
  logic [5:0]       rem, rem_nxt, len_nxt;
  logic [1:0]       addr_nxt;
  logic             push, push_sop, push_eop, pop, done_nxt;
`ifdef ROUTER_RD_PARITY_CHK_EN
  logic [WIDTH-1:0] par, par_nxt;
  logic             err_nxt;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset and channel flush share one clear; a read is never issued while
  // clearing because the returning byte would be discarded anyway.
  assign clr    = ~resetn | soft_reset;
  assign credit = {1'b0, occ} + (OCC_W + 1)'(inflight);
  assign fifo_read_enb = ~clr & ~fifo_empty & (credit < (OCC_W + 1)'(BUF_DEPTH));

  assign head    = buf_mem[rd_ptr];
  assign m_valid = (occ != '0);
  assign m_data  = head[WIDTH-1:0];
  assign m_sop   = m_valid & head[WIDTH+1];
  assign m_eop   = m_valid & head[WIDTH];
  assign pop     = m_valid & m_ready;

  // Parser state register.
  always_ff @(posedge router_clock) begin
    if (clr) state <= HDR;
    else     state <= state_nxt;
  end

  // Parser next-state and per-byte actions; only acts on an arriving byte.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    len_nxt   = pkt_len;
    addr_nxt  = pkt_addr;
    push      = 1'b0;
    push_sop  = 1'b0;
    push_eop  = 1'b0;
    done_nxt  = 1'b0;
`ifdef ROUTER_RD_PARITY_CHK_EN
    par_nxt   = par;
    err_nxt   = 1'b0;
`endif
    if (inflight) begin
      case (state)
        HDR: begin
          len_nxt   = fifo_data[7:2];
          addr_nxt  = fifo_data[1:0];
          rem_nxt   = fifo_data[7:2];
`ifdef ROUTER_RD_PARITY_CHK_EN
          par_nxt   = fifo_data;
`endif
          state_nxt = (fifo_data[7:2] != 6'd0) ? PAY : PAR;
        end
        PAY: begin
          push     = 1'b1;
          push_sop = (rem == pkt_len);
          push_eop = (rem == 6'd1);
          rem_nxt  = rem - 6'd1;
`ifdef ROUTER_RD_PARITY_CHK_EN
          par_nxt  = par ^ fifo_data;
`endif
          if (rem == 6'd1) state_nxt = PAR;
        end
        PAR: begin
          done_nxt  = 1'b1;
`ifdef ROUTER_RD_PARITY_CHK_EN
          err_nxt   = (fifo_data != par);
`endif
          state_nxt = HDR;
        end
        default: state_nxt = HDR;
      endcase
    end
  end

  // Read tracking, packet fields and status pulses.
  always_ff @(posedge router_clock) begin
    if (clr) begin
      inflight <= 1'b0;
      rem      <= '0;
      pkt_len  <= '0;
      pkt_addr <= '0;
      pkt_done <= 1'b0;
    end else begin
      inflight <= fifo_read_enb;
      rem      <= rem_nxt;
      pkt_len  <= len_nxt;
      pkt_addr <= addr_nxt;
      pkt_done <= done_nxt;
    end
  end

`ifdef ROUTER_RD_PARITY_CHK_EN
  // Parity accumulator and registered mismatch flag.
  always_ff @(posedge router_clock) begin
    if (clr) begin
      par     <= '0;
      pkt_err <= 1'b0;
    end else begin
      par     <= par_nxt;
      pkt_err <= err_nxt;
    end
  end
`else
  assign pkt_err = 1'b0;
`endif

  // Payload buffer: circular FIFO of {sop, eop, data}; credit rule keeps it from overflowing.
  always_ff @(posedge router_clock) begin
    if (clr) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= {push_sop, push_eop, fifo_data};
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: tb/tb_router_dst_reader.sv
// Scoreboard bench for router_dst_reader: directed packets, expected beats and
// packet status queued at stimulus time, compared by a negedge monitor.
module tb_router_dst_reader;

`ifdef ROUTER_RD_PARITY_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       router_clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_enb;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_sop, m_eop;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       pkt_done, pkt_err;

  router_dst_reader #(.WIDTH(8), .BUF_DEPTH(4)) dut (
    .router_clock (router_clock),
    .resetn       (resetn),
    .soft_reset   (soft_reset),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_enb(fifo_read_enb),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .pkt_len      (pkt_len),
    .pkt_addr     (pkt_addr),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err)
  );

  always #5 router_clock = ~router_clock;

  // Channel FIFO model: stimulus writes fmem/wr_idx, the read side owns rd_idx.
  logic [7:0] fmem [1024];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge router_clock) begin
    if (soft_reset) rd_idx <= wr_idx;
    else if (fifo_read_enb && !fifo_empty) begin
      fifo_data <= fmem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  typedef struct packed {logic sop; logic eop; logic [7:0] data;} beat_t;
  typedef struct packed {logic [5:0] len; logic [1:0] addr; logic err;} done_t;
  beat_t exp_beats[$];
  done_t exp_done[$];
  beat_t eb;
  done_t ed;
  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;
  int done_cnt = 0;

  // Monitor: compare every accepted beat and every pkt_done against the queues.
  always @(negedge router_clock) begin
    if (resetn && !soft_reset) begin
      if (m_valid && m_ready) begin
        beat_cnt++;
        n_cmp++;
        if (exp_beats.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected got sop=%0b eop=%0b data=%h", m_sop, m_eop, m_data);
        end else begin
          eb = exp_beats.pop_front();
          if ({m_sop, m_eop, m_data} !== eb) begin
            n_err++;
            $display("FAIL beat got sop=%0b eop=%0b data=%h exp sop=%0b eop=%0b data=%h",
                     m_sop, m_eop, m_data, eb.sop, eb.eop, eb.data);
          end
        end
      end
      if (pkt_done) begin
        done_cnt++;
        n_cmp++;
        if (exp_done.size() == 0) begin
          n_err++;
          $display("FAIL done_unexpected got len=%0d addr=%0d err=%0b", pkt_len, pkt_addr, pkt_err);
        end else begin
          ed = exp_done.pop_front();
          if ({pkt_len, pkt_addr, pkt_err} !== ed) begin
            n_err++;
            $display("FAIL done got len=%0d addr=%0d err=%0b exp len=%0d addr=%0d err=%0b",
                     pkt_len, pkt_addr, pkt_err, ed.len, ed.addr, ed.err);
          end
        end
      end else if (pkt_err !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL err_without_done got pkt_err=%0b exp 0", pkt_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    fmem[wr_idx] = b;
    wr_idx++;
  endtask

  task automatic xbeat(input logic s, input logic e, input logic [7:0] d);
    exp_beats.push_back({s, e, d});
  endtask

  task automatic xdone(input logic [5:0] l, input logic [1:0] a, input logic e);
    exp_done.push_back({l, a, e});
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(posedge router_clock);
      #2;
      if (exp_beats.size() == 0 && exp_done.size() == 0 && fifo_empty && !m_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout got pending beats=%0d dones=%0d exp 0", name,
               exp_beats.size(), exp_done.size());
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ctrl"}, {26'd0, fifo_read_enb, m_valid, m_sop, m_eop, pkt_done, pkt_err}, 32'd0);
    chk({name, "_hdr"}, {24'd0, pkt_len, pkt_addr}, 32'd0);
    chk({name, "_data"}, {24'd0, m_data}, 32'd0);
  endtask

  initial begin
    int base;
    int cnt;
    logic [7:0] p;

    // Reset
    repeat (3) @(posedge router_clock);
    #1;
    chk_reset_vals("reset");
    resetn = 1'b1;
    m_ready = 1'b1;
    @(posedge router_clock);
    #1;

    // Good packet
    xbeat(1, 0, 8'hA1); xbeat(0, 0, 8'hB2); xbeat(0, 1, 8'hC3);
    xdone(6'd3, 2'd1, 1'b0);
    put(8'h0D); put(8'hA1); put(8'hB2); put(8'hC3); put(8'hDD);
    wait_idle("good");
    chk("good_len", {26'd0, pkt_len}, 32'd3);
    chk("good_addr", {30'd0, pkt_addr}, 32'd1);

    // Bad parity
    xbeat(1, 0, 8'hA1); xbeat(0, 0, 8'hB2); xbeat(0, 1, 8'hC3);
    xdone(6'd3, 2'd1, CHK);
    put(8'h0D); put(8'hA1); put(8'hB2); put(8'hC3); put(8'hDC);
    wait_idle("badpar");

    // Zero length
    xdone(6'd0, 2'd2, 1'b0);
    put(8'h02); put(8'h02);
    wait_idle("zero");
    chk("zero_addr", {30'd0, pkt_addr}, 32'd2);
    chk("zero_len", {26'd0, pkt_len}, 32'd0);

    // Backpressure with a 63-byte packet
    @(posedge router_clock);
    #1;
    m_ready = 1'b0;
    base = rd_idx;
    p = 8'hFC;
    for (int i = 1; i <= 63; i++) begin
      xbeat(i == 1, i == 63, 8'(i));
      p = p ^ 8'(i);
    end
    xdone(6'd63, 2'd0, 1'b0);
    put(8'hFC);
    for (int i = 1; i <= 63; i++) put(8'(i));
    put(p);
    repeat (20) @(posedge router_clock);
    #1;
    chk("bp_reads", rd_idx - base, 32'd5);
    chk("bp_rd_enb", {31'd0, fifo_read_enb}, 32'd0);
    chk("bp_head", {22'd0, m_valid, m_sop, m_eop, m_data}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h01});
    m_ready = 1'b1;
    cnt = 0;
    repeat (63) begin
      @(negedge router_clock);
      if (m_valid) cnt++;
    end
    chk("bp_stream", cnt, 32'd63);
    wait_idle("bp");

    // Back-to-back packets
    base = done_cnt;
    xbeat(1, 0, 8'h11); xbeat(0, 1, 8'h22);
    xdone(6'd2, 2'd1, 1'b0);
    xbeat(1, 1, 8'h55);
    xdone(6'd1, 2'd3, 1'b0);
    put(8'h09); put(8'h11); put(8'h22); put(8'h3A);
    put(8'h07); put(8'h55); put(8'h52);
    cnt = 0;
    repeat (7) begin
      @(negedge router_clock);
      if (fifo_read_enb) cnt++;
    end
    chk("b2b_reads", cnt, 32'd7);
    wait_idle("b2b");
    chk("b2b_dones", done_cnt - base, 32'd2);

    // soft_reset mid-packet
    base = beat_cnt;
    for (int i = 1; i <= 5; i++) xbeat(i == 1, i == 5, 8'h30 + 8'(i));
    put(8'h14);
    for (int i = 1; i <= 5; i++) put(8'h30 + 8'(i));
    put(8'h14 ^ 8'h31 ^ 8'h32 ^ 8'h33 ^ 8'h34 ^ 8'h35);
    cnt = 0;
    while (beat_cnt < base + 2 && cnt < 50) begin
      @(negedge router_clock);
      cnt++;
    end
    chk("sr_two_beats", {31'd0, beat_cnt >= base + 2}, 32'd1);
    @(posedge router_clock);
    #1;
    soft_reset = 1'b1;
    @(posedge router_clock);
    #1;
    soft_reset = 1'b0;
    exp_beats.delete();
    exp_done.delete();
    chk_reset_vals("sr");

    // Fresh packet after flush
    xbeat(1, 0, 8'hA1); xbeat(0, 0, 8'hB2); xbeat(0, 1, 8'hC3);
    xdone(6'd3, 2'd2, 1'b0);
    put(8'h0E); put(8'hA1); put(8'hB2); put(8'hC3); put(8'hDE);
    wait_idle("fresh");
    chk("fresh_addr", {30'd0, pkt_addr}, 32'd2);
    chk("fresh_len", {26'd0, pkt_len}, 32'd3);

    repeat (3) @(posedge router_clock);
    #1;
    chk("left_beats", exp_beats.size(), 32'd0);
    chk("left_done", exp_done.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
